// File: rtl/wb_trace_checker.sv
// wb_trace_checker
//   Writeback-stage observer for the 5-stage RV32I pipeline. It records every
//   retired register write into a first-word-fall-through trace FIFO that a
//   consumer drains with a valid/ready handshake. It also keeps a shadow copy
//   of the register file, which lets an end-of-test check compare programmed
//   expected register values in hardware.
//
//   Optional feature macro: TRACE_PC_EN
//     defined   : PCW is stored with each FIFO entry and driven on trace_pc
//     undefined : no PC storage, trace_pc is tied to 0
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   RegWriteW/RDW/ResultW/PCW writeback-stage inputs from the pipeline
//   trace_valid/trace_ready  FIFO head handshake
//   trace_rd/data/pc         FIFO head contents (0 when trace_valid=0)
//   overflow                 sticky: an event was dropped because the FIFO was full
//   retire_cnt               count of cycles with RegWriteW=1 (wraps)
//   cfg_we/idx/rd/val        expectation-table write port (ignored while checking)
//   chk_start                starts a check (IDLE or DONE)
//   chk_busy/done/pass       check status; chk_pass is valid when chk_done=1
//   chk_fail_idx             first mismatching expectation entry
module wb_trace_checker #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int NCHK  = 4,
  localparam int IW   = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] PCW,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [4:0]      trace_rd,
  output logic [XLEN-1:0] trace_data,
  output logic [XLEN-1:0] trace_pc,
  output logic            overflow,
  output logic [31:0]     retire_cnt,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [4:0]      cfg_rd,
  input  logic [XLEN-1:0] cfg_val,
  input  logic            chk_start,
  output logic            chk_busy,
  output logic            chk_done,
  output logic            chk_pass,
  output logic [IW-1:0]   chk_fail_idx
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  // ---------------------------------------------------------------- trace FIFO
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     retire_q, retire_d;

  logic fifo_empty, fifo_full, evt, pop, push;

  // The extra MSB tells a full FIFO (MSBs differ) from an empty one (equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign evt  = RegWriteW && (RDW != 5'd0);
  assign pop  = trace_valid && trace_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = evt && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    retire_d   = retire_q;
    if (push)             wr_ptr_d   = wr_ptr_q + 1'b1;
    if (pop)              rd_ptr_d   = rd_ptr_q + 1'b1;
    if (evt && !push)     overflow_d = 1'b1;
    if (RegWriteW)        retire_d   = retire_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      retire_q   <= retire_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q[AW-1:0]]   <= RDW;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= ResultW;
    end
  end

  // Head fields are masked so the outputs read 0 whenever the FIFO is empty.
  assign trace_valid = !fifo_empty;
  assign trace_rd    = trace_valid ? fifo_rd_q[rd_ptr_q[AW-1:0]]   : '0;
  assign trace_data  = trace_valid ? fifo_data_q[rd_ptr_q[AW-1:0]] : '0;
  assign overflow    = overflow_q;
  assign retire_cnt  = retire_q;

`ifdef TRACE_PC_EN
  logic [XLEN-1:0] fifo_pc_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) fifo_pc_q[wr_ptr_q[AW-1:0]] <= PCW;
  end

  assign trace_pc = trace_valid ? fifo_pc_q[rd_ptr_q[AW-1:0]] : '0;
`else
  logic unused_pc;
  assign unused_pc = ^PCW;
  assign trace_pc  = '0;
`endif

  // ------------------------------------------------------- shadow register file
  // Entry 0 is never written; reads of x0 are forced to 0 below anyway.
  logic [XLEN-1:0] shadow_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (evt) begin
      shadow_q[RDW] <= ResultW;
    end
  end

  // --------------------------------------------------------- expectation table
  logic [4:0]      ent_rd_q  [NCHK];
  logic [XLEN-1:0] ent_val_q [NCHK];
  logic [NCHK-1:0] ent_vld_q;
  state_t          state_q, state_d;
  logic            cfg_ok;

  assign cfg_ok = cfg_we && (state_q != S_CHECK) && (int'(cfg_idx) < NCHK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld_q <= '0;
    end else if (cfg_ok) begin
      ent_vld_q[cfg_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      ent_rd_q[cfg_idx]  <= cfg_rd;
      ent_val_q[cfg_idx] <= cfg_val;
    end
  end

  // ------------------------------------------------------------- check FSM
  logic [IW-1:0]   idx_q, idx_d;
  logic            pass_q, pass_d;
  logic [IW-1:0]   fail_q, fail_d;
  logic [4:0]      cur_rd;
  logic [XLEN-1:0] cur_shadow;
  logic            cur_miss;

  // The shadow read is the registered value, i.e. before any same-cycle event.
  assign cur_rd     = ent_rd_q[idx_q];
  assign cur_shadow = (cur_rd == 5'd0) ? '0 : shadow_q[cur_rd];
  assign cur_miss   = ent_vld_q[idx_q] && (cur_shadow != ent_val_q[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (chk_start) begin
          state_d = S_CHECK;
          idx_d   = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
        end
      end
      S_CHECK: begin
        if (cur_miss) begin
          state_d = S_DONE;
          pass_d  = 1'b0;
          fail_d  = idx_q;
        end else if (int'(idx_q) == NCHK - 1) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign chk_busy     = (state_q == S_CHECK);
  assign chk_done     = (state_q == S_DONE);
  assign chk_pass     = pass_q;
  assign chk_fail_idx = fail_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
module tb_wb_trace_checker;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int NCHK  = 4;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            RegWriteW = 1'b0;
  logic [4:0]      RDW = '0;
  logic [XLEN-1:0] ResultW = '0;
  logic [XLEN-1:0] PCW = '0;
  logic            trace_valid;
  logic            trace_ready = 1'b0;
  logic [4:0]      trace_rd;
  logic [XLEN-1:0] trace_data;
  logic [XLEN-1:0] trace_pc;
  logic            overflow;
  logic [31:0]     retire_cnt;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic [4:0]      cfg_rd = '0;
  logic [XLEN-1:0] cfg_val = '0;
  logic            chk_start = 1'b0;
  logic            chk_busy;
  logic            chk_done;
  logic            chk_pass;
  logic [IW-1:0]   chk_fail_idx;

  wb_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .NCHK(NCHK)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .PCW(PCW),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_rd(trace_rd), .trace_data(trace_data), .trace_pc(trace_pc),
    .overflow(overflow), .retire_cnt(retire_cnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rd(cfg_rd), .cfg_val(cfg_val),
    .chk_start(chk_start), .chk_busy(chk_busy), .chk_done(chk_done),
    .chk_pass(chk_pass), .chk_fail_idx(chk_fail_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } tr_t;

  tr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef TRACE_PC_EN
    return pc;
`else
    return 32'd0 & pc;
`endif
  endfunction

  // Scoreboard monitor: a handshake seen at the falling edge is the pop that
  // the next rising edge performs.
  always @(negedge clk) begin
    if (trace_valid && trace_ready) begin
      tr_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL trace_unexpected: got rd=%0d data=0x%08h, no entry expected", trace_rd, trace_data);
      end else begin
        e = exp_q.pop_front();
        check32("trace_rd", 32'(trace_rd), 32'(e.rd));
        check32("trace_data", trace_data, e.data);
        check32("trace_pc", trace_pc, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [4:0] rd, input logic [31:0] v, input logic [31:0] pc, input bit exp_push);
    RegWriteW = 1'b1;
    RDW       = rd;
    ResultW   = v;
    PCW       = pc;
    if (exp_push) exp_q.push_back('{rd, v, exp_pc(pc)});
    step();
  endtask

  task automatic cfg(input logic [IW-1:0] idx, input logic [4:0] rd, input logic [31:0] v);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_rd  = rd;
    cfg_val = v;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic start_chk();
    chk_start = 1'b1;
    step();
    chk_start = 1'b0;
  endtask

  // chk_start was sampled at the edge inside start_chk; allow NCHK more edges.
  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < NCHK; i++) begin
      step();
      if (chk_done) begin
        got = 1'b1;
        break;
      end
    end
    check32({name, "_done_in_time"}, 32'(got), 32'd1);
  endtask

  task automatic drain(input string name);
    trace_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check32({name, "_left"}, exp_q.size(), 32'd0);
    @(negedge clk);
    check32({name, "_valid_after"}, 32'(trace_valid), 32'd0);
    trace_ready = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      RegWriteW   = ~RegWriteW;
      RDW         = 5'(i + 1);
      ResultW     = 32'hDEAD_0000 + 32'(i);
      trace_ready = 1'b1;
      cfg_we      = ~cfg_we;
      chk_start   = ~chk_start;
    end
    @(negedge clk);
    check32("rst_trace_valid", 32'(trace_valid), 32'd0);
    check32("rst_trace_data", trace_data, 32'd0);
    check32("rst_trace_rd_pc", 32'(trace_rd) | trace_pc, 32'd0);
    check32("rst_retire_ovf", retire_cnt | 32'(overflow), 32'd0);
    check32("rst_chk_flags", {28'd0, chk_busy, chk_done, chk_pass, 1'b0} | 32'(chk_fail_idx), 32'd0);
    RegWriteW = 1'b0; cfg_we = 1'b0; chk_start = 1'b0; RDW = '0; ResultW = '0;
    step();
    rst = 1'b0;
    step();

    // 2. Three writes, drained immediately
    ev(5'd1, 32'h0A, 32'h100, 1'b1);
    ev(5'd2, 32'h14, 32'h104, 1'b1);
    ev(5'd3, 32'h1E, 32'h108, 1'b1);
    RegWriteW = 1'b0;
    step();
    step();
    check32("t2_retire", retire_cnt, 32'd3);
    check32("t2_all_seen", exp_q.size(), 32'd0);
    trace_ready = 1'b0;

    // 3. Matching expectations pass
    cfg(2'd0, 5'd1, 32'h0A);
    cfg(2'd1, 5'd2, 32'h14);
    cfg(2'd2, 5'd3, 32'h1E);
    start_chk();
    check32("t3_busy", 32'(chk_busy), 32'd1);
    wait_done("t3");
    check32("t3_pass", 32'(chk_pass), 32'd1);
    check32("t3_busy_after", 32'(chk_busy), 32'd0);

    // 4. Entry 1 mismatch, restart from DONE
    cfg(2'd1, 5'd2, 32'h15);
    start_chk();
    wait_done("t4");
    check32("t4_pass", 32'(chk_pass), 32'd0);
    check32("t4_fail_idx", 32'(chk_fail_idx), 32'd1);

    // 5. Overflow: 17 events into a 16-entry FIFO with no consumer
    for (int i = 1; i <= 17; i++)
      ev(5'd5, 32'(i), 32'h200 + 32'(4 * i), i <= 16);
    RegWriteW = 1'b0;
    step();
    check32("t5_overflow", 32'(overflow), 32'd1);
    check32("t5_retire", retire_cnt, 32'd20);
    check32("t5_valid_full", 32'(trace_valid), 32'd1);
    cfg(2'd0, 5'd5, 32'd17);
    cfg(2'd1, 5'd2, 32'h14);
    start_chk();
    wait_done("t5");
    check32("t5_shadow_x5_pass", 32'(chk_pass), 32'd1);
    drain("t5_drain");

    // 6. Write to x0: counted, not traced, not shadowed
    ev(5'd0, 32'hFFFF, 32'h300, 1'b0);
    RegWriteW = 1'b0;
    step();
    check32("t6_retire", retire_cnt, 32'd21);
    check32("t6_no_trace", 32'(trace_valid), 32'd0);
    cfg(2'd3, 5'd0, 32'd0);
    start_chk();
    wait_done("t6a");
    check32("t6_x0_zero_pass", 32'(chk_pass), 32'd1);
    cfg(2'd3, 5'd0, 32'hFFFF);
    start_chk();
    wait_done("t6b");
    check32("t6_x0_ffff_pass", 32'(chk_pass), 32'd0);
    check32("t6_x0_fail_idx", 32'(chk_fail_idx), 32'd3);

    // Asynchronous reset in the middle of a check
    start_chk();
    check32("rstmid_busy_before", 32'(chk_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check32("rstmid_busy", 32'(chk_busy), 32'd0);
    check32("rstmid_done_pass", {30'd0, chk_done, chk_pass}, 32'd0);
    check32("rstmid_fail_idx", 32'(chk_fail_idx), 32'd0);
    check32("rstmid_retire", retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++)
      ev(5'd7, 32'd200 + 32'(i), 32'h400 + 32'(4 * i), 1'b1);
    trace_ready = 1'b1;
    ev(5'd7, 32'd216, 32'h440, 1'b1);
    trace_ready = 1'b0;
    RegWriteW   = 1'b0;
    step();
    check32("pp_overflow", 32'(overflow), 32'd0);
    check32("pp_retire", retire_cnt, 32'd17);
    drain("pp_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
Writeback-stage observer for the 5-stage RV32I pipeline. Captures every retired register write into a trace FIFO that downstream logic drains with a valid/ready handshake. Keeps a shadow register file. Runs a programmable end-of-test check of expected register values in hardware, replacing hierarchical peeks into the register file. Instantiated next to Pipeline_top and driven from its W-stage signals.

Parameters:
XLEN, 32, datapath width of result/PC
DEPTH, 16, trace FIFO entries (power of 2, >=2)
NCHK, 4, expectation table entries (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
RegWriteW  in  1  writeback enable from pipeline
RDW  in  5  destination register index
ResultW  in  XLEN  writeback data
PCW  in  XLEN  PC of retiring instruction
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_rd  out  5  head register index
trace_data  out  XLEN  head data
trace_pc  out  XLEN  head PC
overflow  out  1  sticky, event dropped on full FIFO
retire_cnt  out  32  count of RegWriteW cycles
cfg_we  in  1  write expectation entry
cfg_idx  in  clog2(NCHK) (min 1)  entry index
cfg_rd  in  5  expected register index
cfg_val  in  XLEN  expected value
chk_start  in  1  start check pulse
chk_busy  out  1  check in progress
chk_done  out  1  check finished, held
chk_pass  out  1  result, valid when chk_done
chk_fail_idx  out  clog2(NCHK) (min 1)  first mismatching entry

Behaviour:
- Reset (async, any time incl. mid-check): FIFO pointers, overflow, retire_cnt, shadow regs, entry valid bits, FSM=IDLE, all outputs 0.
- Event = RegWriteW=1 and RDW!=0. Write to x0: retire_cnt increments; no trace entry; no shadow update.
- retire_cnt increments on every RegWriteW=1 cycle and wraps at 2^32.
- Shadow reg[RDW] <= ResultW on every event, even if the trace push is dropped.
- FIFO is first-word-fall-through. A push at edge N gives trace_valid=1 after edge N. A pop occurs when trace_valid and trace_ready are both 1.
- Push is accepted when not full, or when full and popping in the same cycle. Otherwise the push is dropped and overflow is set. overflow clears only on rst.
- Pointers wrap modulo DEPTH. Full/empty are distinguished with an extra pointer bit.
- cfg_we in IDLE/DONE writes entry[cfg_idx] = {rd, val} and sets its valid bit. cfg_we is ignored while chk_busy=1.
- FSM IDLE: chk_start -> CHECK, idx=0, chk_done=0, chk_pass=0.
- FSM CHECK (chk_busy=1): one entry per cycle; invalid entries are skipped.
  - shadow[rd]!=val -> DONE, chk_pass=0, chk_fail_idx=idx.
  - idx=NCHK-1 with no mismatch -> DONE, chk_pass=1.
  - An entry with rd=0 compares against 0.
- FSM DONE: chk_done=1 held. chk_start -> CHECK (restart). chk_start in CHECK is ignored.
- A compare uses the shadow value before any same-cycle event update.
- Check latency: chk_done rises at most NCHK+1 edges after chk_start is sampled.

Optional Feature:
TRACE_PC_EN:
- Defined: PCW is stored per FIFO entry and driven on trace_pc.
- Undefined: no PC storage; trace_pc is tied to 0. All other behaviour is identical.

Test Plan:
1. Hold rst=1, toggle inputs -> all outputs 0, trace_valid=0. Assert rst during CHECK -> IDLE, chk_busy=0 immediately.
2. Write x1=0x0A, x2=0x14, x3=0x1E with trace_ready=1 -> three trace entries in order (rd 1,2,3; data 0x0A/0x14/0x1E); retire_cnt=3. With TRACE_PC_EN, PCs match.
3. Program entries 0-2 = x1:0x0A, x2:0x14, x3:0x1E (entry 3 invalid), pulse chk_start -> chk_done=1 within 5 edges, chk_pass=1.
4. Reprogram entry 1 = x2:0x15, restart check -> chk_pass=0, chk_fail_idx=1.
5. trace_ready=0, 17 events to x5 with values 1..17 -> 16 entries hold 1..16, overflow=1, shadow x5=17. Then drain -> 16 pops, trace_valid=0.
6. RegWriteW=1, RDW=0, ResultW=0xFFFF -> no trace entry, retire_cnt+1. Expectation x0:0 passes. Full FIFO with simultaneous push+pop -> push accepted, overflow unchanged.
